// File: rtl/ooo_pkg.sv
// Shared definitions for the out-of-order front end: MIPS opcode/funct codes,
// instruction class codes and the decoded issue-queue entry layout.
package ooo_pkg;

    localparam int IQ_VALUE_SIZE = 32;
    localparam int IQ_REGID_BITS = 5;
    localparam int IQ_TYPE_INSTR = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [IQ_TYPE_INSTR-1:0] T_RALU = 4'd0;
    localparam logic [IQ_TYPE_INSTR-1:0] T_IALU = 4'd1;
    localparam logic [IQ_TYPE_INSTR-1:0] T_MEM  = 4'd2;
    localparam logic [IQ_TYPE_INSTR-1:0] T_BR   = 4'd3;
    localparam logic [IQ_TYPE_INSTR-1:0] T_ILL  = 4'd15;

    typedef struct packed {
        logic [IQ_REGID_BITS-1:0] r1addr;
        logic [IQ_REGID_BITS-1:0] r2addr;
        logic [IQ_REGID_BITS-1:0] waddr;
        logic [IQ_TYPE_INSTR-1:0] type_instr;
        logic [IQ_VALUE_SIZE-1:0] immed_val;
        logic [IQ_VALUE_SIZE-1:0] instr;
    } iq_entry_t;

    function automatic logic is_supported_funct(input logic [5:0] funct);
        case (funct)
            F_SLL, F_SRA, F_JR, F_ADD, F_ADDU, F_SUB,
            F_AND, F_OR, F_XOR, F_NOR, F_SLT: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

    function automatic logic [IQ_VALUE_SIZE-1:0] sign_ext16(input logic [15:0] imm);
        return {{(IQ_VALUE_SIZE-16){imm[15]}}, imm};
    endfunction

    function automatic logic [IQ_VALUE_SIZE-1:0] zero_ext16(input logic [15:0] imm);
        return {{(IQ_VALUE_SIZE-16){1'b0}}, imm};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational MIPS decoder: turns one raw instruction word into the
// register/class/immediate fields stored in an issue-queue entry.
module instr_decoder
    import ooo_pkg::*;
(
    input  logic [IQ_VALUE_SIZE-1:0] instr_in,
    output iq_entry_t                entry_out
);

    logic [5:0]               opcode;
    logic [5:0]               funct;
    logic [IQ_REGID_BITS-1:0] rs;
    logic [IQ_REGID_BITS-1:0] rt;
    logic [IQ_REGID_BITS-1:0] rd;
    logic [15:0]              imm;

    assign opcode = instr_in[31:26];
    assign funct  = instr_in[5:0];
    assign rs     = instr_in[25:21];
    assign rt     = instr_in[20:16];
    assign rd     = instr_in[15:11];
    assign imm    = instr_in[15:0];

    // Anything not recognised falls through as an illegal entry that keeps its raw word.
    always_comb begin
        entry_out            = '0;
        entry_out.instr      = instr_in;
        entry_out.type_instr = T_ILL;
        case (opcode)
            OP_RTYPE: begin
                if (is_supported_funct(funct)) begin
                    entry_out.r1addr     = rs;
                    entry_out.r2addr     = rt;
                    entry_out.waddr      = rd;
                    entry_out.type_instr = T_RALU;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                entry_out.r1addr     = rs;
                entry_out.waddr      = rt;
                entry_out.type_instr = T_IALU;
                entry_out.immed_val  = sign_ext16(imm);
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                entry_out.r1addr     = rs;
                entry_out.waddr      = rt;
                entry_out.type_instr = T_IALU;
                entry_out.immed_val  = zero_ext16(imm);
            end
            OP_LUI: begin
                entry_out.waddr      = rt;
                entry_out.type_instr = T_IALU;
                entry_out.immed_val  = {imm, 16'h0000};
            end
            OP_LW: begin
                entry_out.r1addr     = rs;
                entry_out.waddr      = rt;
                entry_out.type_instr = T_MEM;
                entry_out.immed_val  = sign_ext16(imm);
            end
            OP_SW: begin
                entry_out.r1addr     = rs;
                entry_out.r2addr     = rt;
                entry_out.type_instr = T_MEM;
                entry_out.immed_val  = sign_ext16(imm);
            end
            OP_BEQ, OP_BNE: begin
                entry_out.r1addr     = rs;
                entry_out.r2addr     = rt;
                entry_out.type_instr = T_BR;
                entry_out.immed_val  = sign_ext16(imm) << 2;
            end
            OP_BGTZ: begin
                entry_out.r1addr     = rs;
                entry_out.type_instr = T_BR;
                entry_out.immed_val  = sign_ext16(imm) << 2;
            end
            OP_J: begin
                entry_out.type_instr = T_BR;
                entry_out.immed_val  = {4'b0000, instr_in[25:0], 2'b00};
            end
            default: begin
                entry_out.type_instr = T_ILL;
            end
        endcase
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Circular FIFO of decoded instructions feeding dispatch; decodes on enqueue,
// presents the head combinationally and supports a synchronous flush.
module instr_issue_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int VALUE_SIZE = IQ_VALUE_SIZE,
    parameter int REGID_BITS = IQ_REGID_BITS,
    parameter int TYPE_INSTR = IQ_TYPE_INSTR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [VALUE_SIZE-1:0]   in_instr,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic                    stall,
    output logic                    out_valid,
    output logic [REGID_BITS-1:0]   r1addr,
    output logic [REGID_BITS-1:0]   r2addr,
    output logic [REGID_BITS-1:0]   waddr,
    output logic [TYPE_INSTR-1:0]   type_instr,
    output logic [VALUE_SIZE-1:0]   immed_val,
    output logic [VALUE_SIZE-1:0]   instr,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    iq_entry_t        mem_q [DEPTH];
    iq_entry_t        enq_entry;
    iq_entry_t        head_entry;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;

    instr_decoder u_decoder (
        .instr_in  (in_instr),
        .entry_out (enq_entry)
    );

    // in_ready looks only at occupancy, so a full queue refuses a push even while popping.
    assign in_ready  = (count_q < DEPTH_CNT);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush && (in_instr != '0);
    assign pop       = out_valid && !stall && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= enq_entry;
    end

    always_comb begin
        head_entry = '0;
        if (out_valid) head_entry = mem_q[head_q];
    end

    assign r1addr     = head_entry.r1addr;
    assign r2addr     = head_entry.r2addr;
    assign waddr      = head_entry.waddr;
    assign type_instr = head_entry.type_instr;
    assign immed_val  = head_entry.immed_val;
    assign instr      = head_entry.instr;
    assign count      = count_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Self-checking bench for instr_issue_queue: directed scenarios plus randomized
// traffic compared against a word-queue reference model with its own decoder.
module tb_instr_issue_queue;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        stall;
    logic        out_valid;
    logic [4:0]  r1addr, r2addr, waddr;
    logic [3:0]  type_instr;
    logic [31:0] immed_val;
    logic [31:0] instr;
    logic [3:0]  count;

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];

    typedef struct packed {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wa;
        logic [3:0]  ty;
        logic [31:0] imm;
    } dec_t;

    instr_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_instr   (in_instr),
        .in_ready   (in_ready),
        .flush      (flush),
        .stall      (stall),
        .out_valid  (out_valid),
        .r1addr     (r1addr),
        .r2addr     (r2addr),
        .waddr      (waddr),
        .type_instr (type_instr),
        .immed_val  (immed_val),
        .instr      (instr),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t        d;
        logic [5:0]  op;
        logic [31:0] se;
        logic [31:0] ze;
        op = w[31:26];
        se = 32'(signed'(w[15:0]));
        ze = 32'(w[15:0]);
        d  = '{5'd0, 5'd0, 5'd0, 4'd15, 32'd0};
        case (op)
            6'd0:  if (w[5:0] inside {6'h00, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22,
                                     6'h24, 6'h25, 6'h26, 6'h27, 6'h2A})
                       d = '{w[25:21], w[20:16], w[15:11], 4'd0, 32'd0};
            6'd8, 6'd9, 6'd10:   d = '{w[25:21], 5'd0, w[20:16], 4'd1, se};
            6'd12, 6'd13, 6'd14: d = '{w[25:21], 5'd0, w[20:16], 4'd1, ze};
            6'd15: d = '{5'd0, 5'd0, w[20:16], 4'd1, ze * 32'd65536};
            6'h23: d = '{w[25:21], 5'd0, w[20:16], 4'd2, se};
            6'h2B: d = '{w[25:21], w[20:16], 5'd0, 4'd2, se};
            6'd4, 6'd5: d = '{w[25:21], w[20:16], 5'd0, 4'd3, se * 32'd4};
            6'd7:  d = '{w[25:21], 5'd0, 5'd0, 4'd3, se * 32'd4};
            6'd2:  d = '{5'd0, 5'd0, 5'd0, 4'd3, 32'(w[25:0]) * 32'd4};
            default: d = '{5'd0, 5'd0, 5'd0, 4'd15, 32'd0};
        endcase
        return d;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [5:0] ops [14];
        logic [5:0] fns [12];
        logic [31:0] w;
        int sel;
        ops = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09, 6'h0A,
                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h00, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h24, 6'h25,
                6'h26, 6'h27, 6'h2A, 6'h18};
        sel = $urandom_range(0, 9);
        if (sel == 0) return 32'h0;
        if (sel == 1) return $urandom();
        w = $urandom();
        w[31:26] = ops[$urandom_range(0, 13)];
        if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 11)];
        return w;
    endfunction

    // Advances one clock and updates the reference queue from the inputs seen at the edge.
    task automatic cycle();
        bit p, q;
        @(posedge clk);
        p = rst && in_valid && (mq.size() < DEPTH) && !flush && (in_instr != 32'h0);
        q = rst && (mq.size() != 0) && !stall && !flush;
        if (!rst || flush) begin
            mq.delete();
        end else begin
            if (q) void'(mq.pop_front());
            if (p) mq.push_back(in_instr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL reset_flags: got ready=%0b valid=%0b count=%0d, want 1 0 0",
                     in_ready, out_valid, count);
        end
        checks++;
        if ({r1addr, r2addr, waddr, type_instr, immed_val, instr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_head: got r1=%0d r2=%0d wa=%0d ty=%0d imm=%h instr=%h, want all 0",
                     r1addr, r2addr, waddr, type_instr, immed_val, instr);
        end
        rst = 1'b1;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_decode_table();
        logic [31:0] words [9];
        logic [50:0] exps  [9];
        words = '{32'h00221820, 32'h2085FFFF, 32'h34068000, 32'h3C071234, 32'h1022FFFF,
                  32'h08000010, 32'hACC50008, 32'h1C600002, 32'h00220018};
        exps  = '{{5'd1, 5'd2, 5'd3, 4'd0,  32'h00000000},
                  {5'd4, 5'd0, 5'd5, 4'd1,  32'hFFFFFFFF},
                  {5'd0, 5'd0, 5'd6, 4'd1,  32'h00008000},
                  {5'd0, 5'd0, 5'd7, 4'd1,  32'h12340000},
                  {5'd1, 5'd2, 5'd0, 4'd3,  32'hFFFFFFFC},
                  {5'd0, 5'd0, 5'd0, 4'd3,  32'h00000040},
                  {5'd6, 5'd5, 5'd0, 4'd2,  32'h00000008},
                  {5'd3, 5'd0, 5'd0, 4'd3,  32'h00000008},
                  {5'd0, 5'd0, 5'd0, 4'd15, 32'h00000000}};
        stall = 1'b0;
        for (int k = 0; k < 9; k++) begin
            in_valid = 1'b1; in_instr = words[k];
            cycle();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || {r1addr, r2addr, waddr, type_instr, immed_val} !== exps[k]
                || instr !== words[k]) begin
                errors++;
                $display("[TB] FAIL decode[%0d]: got v=%0b %h instr=%h, want v=1 %h instr=%h", k,
                         out_valid, {r1addr, r2addr, waddr, type_instr, immed_val}, instr,
                         exps[k], words[k]);
            end
            cycle();
            checks++;
            if (out_valid !== 1'b0 || count !== 4'd0) begin
                errors++;
                $display("[TB] FAIL decode_drain[%0d]: got valid=%0b count=%0d, want 0 0",
                         k, out_valid, count);
            end
        end
    endtask

    task automatic test_full_queue();
        logic [31:0] ew;
        dec_t d;
        stall = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1; in_instr = 32'h8C470004 + 32'(i);
            cycle();
        end
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_flags: got count=%0d ready=%0b valid=%0b, want 8 0 1",
                     count, in_ready, out_valid);
        end
        checks++;
        if ({r1addr, r2addr, waddr, type_instr, immed_val, instr} !==
            {5'd2, 5'd0, 5'd7, 4'd2, 32'd4, 32'h8C470004}) begin
            errors++;
            $display("[TB] FAIL full_head: got r1=%0d wa=%0d ty=%0d imm=%h instr=%h, want 2 7 2 4 8c470004",
                     r1addr, waddr, type_instr, immed_val, instr);
        end
        stall = 1'b0; in_valid = 1'b1; in_instr = 32'h8C470040;
        cycle();
        checks++;
        if (count !== 4'd7 || instr !== 32'h8C470005) begin
            errors++;
            $display("[TB] FAIL full_pop_refuse: got count=%0d head=%h, want 7 8c470005", count, instr);
        end
        stall = 1'b1;
        cycle();
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL full_refill: got count=%0d ready=%0b, want 8 0", count, in_ready);
        end
        in_valid = 1'b0; stall = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ew = (j < 7) ? (32'h8C470005 + 32'(j)) : 32'h8C470040;
            d  = ref_decode(ew);
            checks++;
            if (instr !== ew || {r1addr, r2addr, waddr, type_instr, immed_val} !== d) begin
                errors++;
                $display("[TB] FAIL drain_order[%0d]: got instr=%h imm=%h, want instr=%h imm=%h",
                         j, instr, immed_val, ew, d.imm);
            end
            cycle();
        end
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_empty: got count=%0d valid=%0b, want 0 0", count, out_valid);
        end
    endtask

    task automatic test_nop_illegal();
        stall = 1'b1; in_valid = 1'b1; in_instr = 32'h0;
        cycle();
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nop_dropped: got count=%0d valid=%0b, want 0 0", count, out_valid);
        end
        in_instr = 32'hFC000000;
        cycle();
        checks++;
        if (count !== 4'd1 || type_instr !== 4'd15 || {r1addr, r2addr, waddr, immed_val} !== '0
            || instr !== 32'hFC000000) begin
            errors++;
            $display("[TB] FAIL illegal_entry: got count=%0d ty=%0d r1=%0d r2=%0d wa=%0d imm=%h instr=%h, want 1 15 0 0 0 0 fc000000",
                     count, type_instr, r1addr, r2addr, waddr, immed_val, instr);
        end
        in_valid = 1'b0; stall = 1'b0;
        cycle();
    endtask

    task automatic test_flush_reset();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = 32'h8C470004 + 32'(i);
            cycle();
        end
        checks++;
        if (count !== 4'd5) begin
            errors++;
            $display("[TB] FAIL flush_fill: got count=%0d, want 5", count);
        end
        flush = 1'b1; stall = 1'b0; in_valid = 1'b1; in_instr = 32'h00221820;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (count !== 4'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL flush_empty: got count=%0d valid=%0b ready=%0b, want 0 0 1",
                     count, out_valid, in_ready);
        end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = 32'h2085FFFF + 32'(i);
            cycle();
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got count=%0d ready=%0b valid=%0b, want 0 1 0",
                     count, in_ready, out_valid);
        end
        in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        in_valid = 1'b1; in_instr = 32'h34068000;
        cycle();
        in_valid = 1'b0;
        checks++;
        if (count !== 4'd1 || instr !== 32'h34068000 || immed_val !== 32'h00008000) begin
            errors++;
            $display("[TB] FAIL resume_after_reset: got count=%0d instr=%h imm=%h, want 1 34068000 00008000",
                     count, instr, immed_val);
        end
        stall = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        dec_t        d;
        logic [31:0] ew;
        for (int c = 0; c < 800; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 2) == 0);
            flush    = ($urandom_range(0, 40) == 0);
            in_instr = rand_word();
            if (mq.size() != 0) begin
                ew = mq[0];
                d  = ref_decode(ew);
            end else begin
                ew = '0;
                d  = '0;
            end
            checks++;
            if (count !== 4'(mq.size()) || in_ready !== (mq.size() < DEPTH)
                || out_valid !== (mq.size() != 0)) begin
                errors++;
                $display("[TB] FAIL rand_flags[%0d]: got count=%0d ready=%0b valid=%0b, want count=%0d",
                         c, count, in_ready, out_valid, mq.size());
            end
            checks++;
            if ({r1addr, r2addr, waddr, type_instr, immed_val} !== d || instr !== ew) begin
                errors++;
                $display("[TB] FAIL rand_head[%0d]: got %h instr=%h, want %h instr=%h",
                         c, {r1addr, r2addr, waddr, type_instr, immed_val}, instr, d, ew);
            end
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_table();
        test_full_queue();
        test_nop_illegal();
        test_flush_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_issue_queue.md
# instr_issue_queue

Decoded-instruction buffer sitting directly upstream of the out-of-order dispatch/control stage. Accepts raw 32-bit MIPS instruction words from fetch, decodes each into register addresses, instruction class and extended immediate, and holds decoded entries in a circular FIFO. The head entry drives the dispatch stage's instruction-input bus, and the queue advances only when dispatch does not assert `stall`. Supports flush for branch recovery.

## Interface
- `DEPTH`, 8: queue entries; power of two, at least 2
- `VALUE_SIZE`, 32: instruction and immediate width
- `REGID_BITS`, 5: architectural register index width
- `TYPE_INSTR`, 4: instruction-class code width
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  fetch presents `in_instr`
- `in_instr`  in  VALUE_SIZE  raw instruction word
- `in_ready`  out  1  queue can accept this cycle
- `flush`  in  1  discard all queued entries
- `stall`  in  1  dispatch cannot take head this cycle
- `out_valid`  out  1  head entry is valid
- `r1addr`, `r2addr`, `waddr`  out  REGID_BITS each  decoded source and destination registers
- `type_instr`  out  TYPE_INSTR  0 R-type ALU, 1 I-type ALU, 2 LW/SW, 3 branch/jump, 15 illegal
- `immed_val`  out  VALUE_SIZE  extended immediate
- `instr`  out  VALUE_SIZE  original word of head entry
- `count`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Decode occurs at enqueue; decoded fields are stored per entry.
- Decode rules use rs=[25:21], rt=[20:16], rd=[15:11] and imm=[15:0]:
  - R-type (opcode 0; funct ADD, ADDU, AND, NOR, OR, SLT, SUB, XOR, SRA, SLL, JR): r1=rs, r2=rt, waddr=rd, type 0, immed 0.
  - ADDI, ADDIU, SLTI: r1=rs, waddr=rt, r2=0, type 1, immed sign-extended.
  - ANDI, ORI, XORI: same fields, immed zero-extended.
  - LUI: immed={imm,16'b0}, r1=0.
  - LW: r1=rs, waddr=rt, type 2, immed sign-extended.
  - SW: r1=rs, r2=rt, waddr=0, type 2, immed sign-extended.
  - BEQ, BNE, BGTZ: r1=rs, r2=rt (0 for BGTZ), waddr=0, type 3, immed = sign-extended imm shifted left 2.
  - J: type 3, immed={4'b0,instr[25:0],2'b00}, all register fields 0.
  - Any other opcode or R-type funct: type 15, all other fields 0. The entry is still enqueued.
- The all-zero word (NOP) is accepted but not enqueued.
- Push condition: `in_valid && in_ready && !flush && in_instr!=0`.
- `in_ready = (count < DEPTH)`. It is not combinationally dependent on `stall`, so a full queue that is popping in the same cycle still refuses the push.
- Pop condition: `out_valid && !stall && !flush`.
- `out_valid = (count != 0)`. When the queue is empty, all head outputs read 0.
- A push and a pop in the same cycle leave `count` unchanged. Both pointers wrap modulo DEPTH.
- `flush` is synchronous. The next cycle has head and tail pointers equal and count 0. A push or pop in the flush cycle is discarded.
- Reset clears pointers and count. Entry storage needs no reset.
- Reset values of outputs: `in_ready`=1, `out_valid`=0, `count`=0, all head fields 0.

## Timing
- Enqueue-to-head latency is 1 cycle: a word accepted at edge N appears on the outputs after edge N if the queue was empty.
- Head outputs are read combinationally from registered storage and the head pointer. There is no path from `stall` to head data.
- `stall` held high freezes the head entry and all its outputs indefinitely.
- Asserting `rst` mid-operation empties the queue immediately and asynchronously. Operation resumes on the first edge after deassertion.

## Structure
- The shared package `ooo_pkg` holds:
  - opcode and funct constants
  - class codes (`T_RALU`=0, `T_IALU`=1, `T_MEM`=2, `T_BR`=3, `T_ILL`=15)
  - packed struct `iq_entry_t` {r1addr, r2addr, waddr, type_instr, immed_val, instr}
- Sub-module `instr_decoder` is purely combinational: word in, `iq_entry_t` out. The queue instantiates it once on the enqueue path.

## Test plan
- ADD r3,r1,r2 (0x00221820), stall=0 → next cycle out_valid=1, r1addr=1, r2addr=2, waddr=3, type_instr=0, then empty.
- ADDI r5,r4,-1 (0x2085FFFF) → r1addr=4, waddr=5, type_instr=1, immed_val=0xFFFFFFFF. ORI r6,r0,0x8000 (0x34068000) → immed_val=0x00008000.
- Stall=1, push 9 distinct LW words starting with 0x8C470004 → first 8 accepted, `in_ready`=0, count=8. Release stall → entries emerge in order, LW head shows r1addr=2, waddr=7, type_instr=2, immed_val=4.
- Full queue with stall=0 and in_valid=1 → pop occurs, push refused that cycle, count=7. Next cycle push accepted, count=8.
- Push 0x00000000 and 0xFC000000 → NOP dropped (count unchanged), illegal word enqueued with type_instr=15.
- Queue holding 5 entries: assert flush with in_valid=1 → next cycle count=0, out_valid=0. Then pulse rst low mid-burst → count=0 and in_ready=1 immediately.
